spi_sram_bridge: RTL and testbench
==================================

// Module: spi_sram_bridge
// PURPOSE
//  SPI slave (mode 0, MSB first) to single-port SRAM bridge with parametrised address/data width and auto-increment bursts.
//  Runs entirely in the system clock domain: SCK, SS_n and MOSI are synchronised and edge-detected.
//  Decodes instruction and address, then streams words to SRAM (write) or from SRAM (read) until SS_n deasserts.
//  Successor to the SCK-clocked single-byte SPI/SRAM interface.
// PARAMETERS
//  ADDR_W       8  SRAM address width; also the number of address bits shifted in after the instruction
//  DATA_W       8  SRAM word width; bits per data word on the SPI bus
//  SYNC_STAGES  2  flip-flop stages on SCK, SS_n and MOSI (>=2)
// PORTS
//  clk          in   1       system clock; must be >= 4x SCK frequency
//  rst_n        in   1       asynchronous active-low reset
//  SCK          in   1       SPI clock from master
//  SS_n         in   1       SPI slave select, active low
//  MOSI         in   1       SPI data from master
//  MISO         out  1       SPI data to master
//  sram_addr    out  ADDR_W  SRAM address
//  sram_wdata   out  DATA_W  SRAM write data
//  sram_we      out  1       one-clk write strobe
//  sram_re      out  1       one-clk read strobe
//  sram_rdata   in   DATA_W  SRAM read data, valid the clk after sram_re
//  done         out  1       one-clk pulse per completed data word (read or write)
//  busy         out  1       high while SS_n (synchronised) is low
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; shift registers, bit counter and address register cleared.
//  Edges: rise/fall detected from the last two synchronised SCK samples; SS_n uses the synchronised value.
//  MOSI is sampled on the detected rising edge; MISO changes on the detected falling edge.
//  Frame layout: 8-bit instruction, ADDR_W address bits, then an unbounded sequence of DATA_W-bit words.
//  Instructions: 0x02 WRITE, 0x03 READ; any other value -> IGNORE.
//  FSM: IDLE -(SS_n low)-> INSTR -(8 bits)-> ADDR | IGNORE.
//       ADDR -(ADDR_W bits)-> WDATA (WRITE) | RDATA (READ).
//       Any state -(SS_n high)-> IDLE, taking effect the same clk as the synchronised SS_n rises.
//  WDATA: after the last bit of each word, drive sram_addr/sram_wdata and pulse sram_we and done for one clk.
//         Then increment the address.
//  RDATA: in the clk after the final address bit, pulse sram_re at the start address.
//         On the next clk, load sram_rdata into the TX shifter; MISO = MSB before the first data falling edge.
//         On each word's last falling edge, reload from the prefetch: sram_re is issued at addr+1 immediately after each load.
//         done pulses when a word's last bit has shifted out.
//  Address: increments modulo 2^ADDR_W after every word; 2^ADDR_W-1 wraps to 0 with no flag.
//  Abort: SS_n high mid-word discards the partial word; no sram_we is issued and the address is not incremented.
//  MISO is 0 outside RDATA (and the RDSR response).
//  IGNORE: bits are consumed with no SRAM access and done is never pulsed.
//  SCK edges while SS_n is high are ignored.
//  rst_n low mid-frame: immediate return to the reset state.
//    After release, the bridge waits in IDLE for the next SS_n falling edge; the remainder of the current frame is not decoded.
//  sram_we and sram_re are never high in the same clk.
// CONFIGURATION
//  SPI_RDSR_EN defined:
//    Instruction 0x05 returns an 8-bit status (no address phase): {6'b0, illegal_instr, aborted}.
//      aborted       = a previous frame ended mid-word.
//      illegal_instr = an unknown instruction was received.
//    Both flags are sticky and cleared when the 8th status bit shifts out; the frame then continues in IGNORE.
//  SPI_RDSR_EN undefined: no status register; 0x05 is an illegal instruction -> IGNORE.
// TESTING
//  WRITE 0x02, addr 0x10, data 0xA5 -> one sram_we with addr=0x10, wdata=0xA5; one done pulse.
//  Burst WRITE at addr 0xFE, data 0x11,0x22,0x33 -> writes to 0xFE,0xFF,0x00 (wrap); three done pulses.
//  READ 0x03, addr 0x20, SRAM[0x20]=0x3C, SRAM[0x21]=0xC3, 16 SCKs -> MISO shows 0x3C then 0xC3.
//    sram_re is pulsed at 0x20, 0x21 and 0x22.
//  WRITE with SS_n raised after 5 data bits -> no sram_we, FSM=IDLE.
//    A following WRITE to 0x05 with data 0x77 succeeds normally.
//  Instruction 0x9F -> no SRAM strobes and MISO stays 0.
//    With SPI_RDSR_EN, a following 0x05 frame returns 0x02; a second 0x05 frame returns 0x00.
//  Assert rst_n during the RDATA phase -> all outputs 0 asynchronously; the next full READ frame works.

Source files
------------

// File: rtl/spi_sram_bridge.sv
// SPI mode-0 slave to single-port SRAM bridge with auto-increment bursts, fully in the clk domain.
// Optional status read (instruction 0x05) is compiled in when SPI_RDSR_EN is defined.
module spi_sram_bridge #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SCK,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we,
    output logic              sram_re,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              done,
    output logic              busy
);

    localparam int SH_W  = (ADDR_W > DATA_W) ? ((ADDR_W > 8) ? ADDR_W : 8)
                                             : ((DATA_W > 8) ? DATA_W : 8);
    localparam int CNT_W = $clog2(SH_W + 1);

    localparam logic [CNT_W-1:0] INSTR_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] DATA_FULL  = CNT_W'(DATA_W);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] INSTR  = 3'd1;
    localparam logic [2:0] ADDR   = 3'd2;
    localparam logic [2:0] WDATA  = 3'd3;
    localparam logic [2:0] RDATA  = 3'd4;
    localparam logic [2:0] IGNORE = 3'd5;
`ifdef SPI_RDSR_EN
    localparam logic [2:0] RDSR   = 3'd6;
`endif

    logic [SYNC_STAGES-1:0] sckSync;
    logic [SYNC_STAGES-1:0] ssSync;
    logic [SYNC_STAGES-1:0] mosiSync;
    logic [SYNC_STAGES-1:0] validSync;
    logic                   sckPrev;
    logic                   ssPrev;

    logic                   sckS;
    logic                   ssS;
    logic                   mosiS;
    logic                   sckRise;
    logic                   sckFall;
    logic                   ssFall;

    logic [2:0]             state;
    logic [CNT_W-1:0]       bitCnt;
    logic [SH_W-2:0]        rxShift;
    logic [SH_W-1:0]        newBits;
    logic [7:0]             instrByte;
    logic [ADDR_W-1:0]      addrReg;
    logic [DATA_W-1:0]      txShift;
    logic [DATA_W-1:0]      prefetch;
    logic                   readMode;
    logic                   rdPend;
    logic                   firstLoad;
`ifdef SPI_RDSR_EN
    logic [7:0]             statShift;
    logic                   aborted;
    logic                   illegalInstr;
`endif

    // SS_n chain resets to "deselected" so reset never looks like an active frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sckSync   <= '0;
            ssSync    <= '1;
            mosiSync  <= '0;
            validSync <= '0;
            sckPrev   <= 1'b0;
            ssPrev    <= 1'b0;
        end else begin
            sckSync   <= {sckSync[SYNC_STAGES-2:0], SCK};
            ssSync    <= {ssSync[SYNC_STAGES-2:0], SS_n};
            mosiSync  <= {mosiSync[SYNC_STAGES-2:0], MOSI};
            validSync <= {validSync[SYNC_STAGES-2:0], 1'b1};
            sckPrev   <= sckS;
            // Only a genuinely observed high SS_n can arm the next frame start
            ssPrev    <= validSync[SYNC_STAGES-1] ? ssS : 1'b0;
        end
    end

    assign sckS      = sckSync[SYNC_STAGES-1];
    assign ssS       = ssSync[SYNC_STAGES-1];
    assign mosiS     = mosiSync[SYNC_STAGES-1];
    assign sckRise   = sckS & ~sckPrev;
    assign sckFall   = ~sckS & sckPrev;
    assign ssFall    = ssPrev & ~ssS;
    assign busy      = ~ssS;
    assign newBits   = {rxShift, mosiS};
    assign instrByte = newBits[7:0];

    always_comb begin
        MISO = 1'b0;
        if (state == RDATA) begin
            MISO = txShift[DATA_W-1];
        end
`ifdef SPI_RDSR_EN
        if (state == RDSR) begin
            MISO = statShift[7];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bitCnt       <= '0;
            rxShift      <= '0;
            addrReg      <= '0;
            txShift      <= '0;
            prefetch     <= '0;
            readMode     <= 1'b0;
            rdPend       <= 1'b0;
            firstLoad    <= 1'b0;
            sram_addr    <= '0;
            sram_wdata   <= '0;
            sram_we      <= 1'b0;
            sram_re      <= 1'b0;
            done         <= 1'b0;
`ifdef SPI_RDSR_EN
            statShift    <= '0;
            aborted      <= 1'b0;
            illegalInstr <= 1'b0;
`endif
        end else begin
            sram_we <= 1'b0;
            sram_re <= 1'b0;
            done    <= 1'b0;
            rdPend  <= sram_re;

            if (ssS) begin
`ifdef SPI_RDSR_EN
                if ((state == WDATA && bitCnt != '0) ||
                    (state == RDATA && bitCnt != '0 && bitCnt != DATA_FULL)) begin
                    aborted <= 1'b1;
                end
`endif
                state  <= IDLE;
                rdPend <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ssFall) begin
                            state   <= INSTR;
                            bitCnt  <= '0;
                            rxShift <= '0;
                            txShift <= '0;
                        end
                    end

                    INSTR: begin
                        if (sckRise) begin
                            rxShift <= newBits[SH_W-2:0];
                            if (bitCnt == INSTR_LAST) begin
                                bitCnt <= '0;
                                case (instrByte)
                                    8'h02: begin
                                        state    <= ADDR;
                                        readMode <= 1'b0;
                                    end
                                    8'h03: begin
                                        state    <= ADDR;
                                        readMode <= 1'b1;
                                    end
`ifdef SPI_RDSR_EN
                                    8'h05: begin
                                        state     <= RDSR;
                                        statShift <= {6'b0, illegalInstr, aborted};
                                    end
`endif
                                    default: begin
                                        state <= IGNORE;
`ifdef SPI_RDSR_EN
                                        illegalInstr <= 1'b1;
`endif
                                    end
                                endcase
                            end else begin
                                bitCnt <= bitCnt + CNT_W'(1);
                            end
                        end
                    end

                    ADDR: begin
                        if (sckRise) begin
                            rxShift <= newBits[SH_W-2:0];
                            if (bitCnt == ADDR_LAST) begin
                                bitCnt <= '0;
                                if (readMode) begin
                                    // Fetch the first word now; addrReg tracks the next fetch
                                    state     <= RDATA;
                                    sram_addr <= newBits[ADDR_W-1:0];
                                    sram_re   <= 1'b1;
                                    addrReg   <= newBits[ADDR_W-1:0] + ADDR_W'(1);
                                    firstLoad <= 1'b1;
                                end else begin
                                    state   <= WDATA;
                                    addrReg <= newBits[ADDR_W-1:0];
                                end
                            end else begin
                                bitCnt <= bitCnt + CNT_W'(1);
                            end
                        end
                    end

                    WDATA: begin
                        if (sckRise) begin
                            rxShift <= newBits[SH_W-2:0];
                            if (bitCnt == DATA_LAST) begin
                                bitCnt     <= '0;
                                sram_addr  <= addrReg;
                                sram_wdata <= newBits[DATA_W-1:0];
                                sram_we    <= 1'b1;
                                done       <= 1'b1;
                                addrReg    <= addrReg + ADDR_W'(1);
                            end else begin
                                bitCnt <= bitCnt + CNT_W'(1);
                            end
                        end
                    end

                    RDATA: begin
                        if (rdPend) begin
                            if (firstLoad) begin
                                txShift   <= sram_rdata;
                                firstLoad <= 1'b0;
                                sram_addr <= addrReg;
                                sram_re   <= 1'b1;
                                addrReg   <= addrReg + ADDR_W'(1);
                            end else begin
                                prefetch <= sram_rdata;
                            end
                        end
                        if (sckRise) begin
                            bitCnt <= bitCnt + CNT_W'(1);
                            if (bitCnt == DATA_LAST) begin
                                done <= 1'b1;
                            end
                        end else if (sckFall) begin
                            // bitCnt==0 is the fall before a word's first bit: MSB must stay put
                            if (bitCnt == DATA_FULL) begin
                                txShift   <= prefetch;
                                bitCnt    <= '0;
                                sram_addr <= addrReg;
                                sram_re   <= 1'b1;
                                addrReg   <= addrReg + ADDR_W'(1);
                            end else if (bitCnt != '0) begin
                                txShift <= {txShift[DATA_W-2:0], 1'b0};
                            end
                        end
                    end

`ifdef SPI_RDSR_EN
                    RDSR: begin
                        if (sckRise) begin
                            if (bitCnt == INSTR_LAST) begin
                                bitCnt       <= '0;
                                state        <= IGNORE;
                                aborted      <= 1'b0;
                                illegalInstr <= 1'b0;
                            end else begin
                                bitCnt <= bitCnt + CNT_W'(1);
                            end
                        end else if (sckFall && bitCnt != '0) begin
                            statShift <= {statShift[6:0], 1'b0};
                        end
                    end
`endif

                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_sram_bridge.sv
// Directed bench for spi_sram_bridge: expected SRAM strobes and MISO bytes are queued by the
// stimulus and checked by independent monitors as the DUT produces them.
module tb_spi_sram_bridge;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       SCK = 1'b0;
    logic       SS_n = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [7:0] sram_addr;
    logic [7:0] sram_wdata;
    logic       sram_we;
    logic       sram_re;
    logic [7:0] sram_rdata;
    logic       done;
    logic       busy;

    spi_sram_bridge #(
        .ADDR_W(8),
        .DATA_W(8),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .SCK(SCK),
        .SS_n(SS_n),
        .MOSI(MOSI),
        .MISO(MISO),
        .sram_addr(sram_addr),
        .sram_wdata(sram_wdata),
        .sram_we(sram_we),
        .sram_re(sram_re),
        .sram_rdata(sram_rdata),
        .done(done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [256];
    logic [15:0] weQ [$];
    logic [7:0]  reQ [$];
    logic [7:0]  misoQ [$];
    int          vectors = 0;
    int          miscompares = 0;
    int          doneCnt = 0;
    logic        misoMon = 1'b0;
    logic [7:0]  rxByte = 8'h00;
    int          rxBits = 0;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endfunction

    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_wdata;
        if (sram_re) sram_rdata <= mem[sram_addr];
    end

    always @(negedge clk) begin
        if (sram_we || sram_re) check("we_re_exclusive", {31'b0, sram_we & sram_re}, 32'h0);
        if (sram_we) begin
            if (weQ.size() == 0) check("unexpected_write", {16'b0, sram_addr, sram_wdata}, 32'hFFFF_FFFF);
            else check("sram_write", {16'b0, sram_addr, sram_wdata}, {16'b0, weQ.pop_front()});
        end
        if (sram_re) begin
            if (reQ.size() == 0) check("unexpected_read", {24'b0, sram_addr}, 32'hFFFF_FFFF);
            else check("sram_read_addr", {24'b0, sram_addr}, {24'b0, reQ.pop_front()});
        end
        if (done) doneCnt++;
    end

    always @(posedge SCK) begin
        if (misoMon) begin
            rxByte = {rxByte[6:0], MISO};
            rxBits++;
            if (rxBits == 8) begin
                rxBits = 0;
                if (misoQ.size() == 0) check("unexpected_miso", {24'b0, rxByte}, 32'hFFFF_FFFF);
                else check("miso_byte", {24'b0, rxByte}, {24'b0, misoQ.pop_front()});
            end
        end
    end

    task automatic sendBits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            SCK  = 1'b0;
            MOSI = val[i];
            #80;
            SCK = 1'b1;
            #80;
        end
    endtask

    task automatic startFrame();
        SCK  = 1'b0;
        SS_n = 1'b0;
        #200;
    endtask

    task automatic endFrame();
        SCK  = 1'b0;
        SS_n = 1'b1;
        MOSI = 1'b0;
        #200;
    endtask

    task automatic readFrame(input logic [7:0] addr, input int nBits);
        startFrame();
        sendBits(32'h03, 8);
        sendBits({24'b0, addr}, 8);
        rxBits  = 0;
        misoMon = 1'b1;
        sendBits(32'h0, nBits);
        misoMon = 1'b0;
        endFrame();
    endtask

    int d0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        sram_rdata = 8'h00;
        #103;
        check("reset_outputs", {7'b0, MISO, sram_we, sram_re, done, busy, sram_addr, sram_wdata}, 32'h0);
        rst_n = 1'b1;
        #100;

        // Single write
        d0 = doneCnt;
        weQ.push_back(16'h10A5);
        startFrame();
        check("busy_in_frame", {31'b0, busy}, 32'h1);
        sendBits(32'h02, 8);
        sendBits(32'h10, 8);
        sendBits(32'hA5, 8);
        endFrame();
        check("busy_after_frame", {31'b0, busy}, 32'h0);
        check("write_done_count", doneCnt - d0, 1);
        check("mem_10", {24'b0, mem[8'h10]}, 32'hA5);

        // Burst write wrapping through 0xFF -> 0x00
        d0 = doneCnt;
        weQ.push_back(16'hFE11);
        weQ.push_back(16'hFF22);
        weQ.push_back(16'h0033);
        startFrame();
        sendBits(32'h02, 8);
        sendBits(32'hFE, 8);
        sendBits(32'h112233, 24);
        endFrame();
        check("burst_done_count", doneCnt - d0, 3);

        // Burst read with prefetch
        mem[8'h20] = 8'h3C;
        mem[8'h21] = 8'hC3;
        mem[8'h22] = 8'h5A;
        d0 = doneCnt;
        reQ.push_back(8'h20);
        reQ.push_back(8'h21);
        reQ.push_back(8'h22);
        misoQ.push_back(8'h3C);
        misoQ.push_back(8'hC3);
        readFrame(8'h20, 16);
        check("read_done_count", doneCnt - d0, 2);

        // Aborted write, then a normal one
        d0 = doneCnt;
        startFrame();
        sendBits(32'h02, 8);
        sendBits(32'h30, 8);
        sendBits(32'h15, 5);
        endFrame();
        check("abort_done_count", doneCnt - d0, 0);
        check("abort_mem_30", {24'b0, mem[8'h30]}, 32'h0);
        weQ.push_back(16'h0577);
        startFrame();
        sendBits(32'h02, 8);
        sendBits(32'h05, 8);
        sendBits(32'h77, 8);
        endFrame();
        check("post_abort_done_count", doneCnt - d0, 1);

        // Unknown instruction: no strobes, MISO low
        d0 = doneCnt;
        misoQ.push_back(8'h00);
        misoQ.push_back(8'h00);
        startFrame();
        sendBits(32'h9F, 8);
        rxBits  = 0;
        misoMon = 1'b1;
        sendBits(32'hFFFF, 16);
        misoMon = 1'b0;
        endFrame();
        check("ignore_done_count", doneCnt - d0, 0);

`ifdef SPI_RDSR_EN
        rst_n = 1'b0;
        #50;
        rst_n = 1'b1;
        #100;
        startFrame();
        sendBits(32'h9F, 8);
        endFrame();
        for (int k = 0; k < 2; k++) begin
            misoQ.push_back(k == 0 ? 8'h02 : 8'h00);
            startFrame();
            sendBits(32'h05, 8);
            rxBits  = 0;
            misoMon = 1'b1;
            sendBits(32'h0, 8);
            misoMon = 1'b0;
            endFrame();
        end
`endif

        // Asynchronous reset in the middle of a read
        d0 = doneCnt;
        reQ.push_back(8'h20);
        reQ.push_back(8'h21);
        startFrame();
        sendBits(32'h03, 8);
        sendBits(32'h20, 8);
        sendBits(32'h0, 3);
        check("busy_before_reset", {31'b0, busy}, 32'h1);
        check("miso_before_reset", {31'b0, MISO}, 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {7'b0, MISO, sram_we, sram_re, done, busy, sram_addr, sram_wdata}, 32'h0);
        #50;
        rst_n = 1'b1;
        #100;
        // Remainder of the interrupted frame must not be decoded
        sendBits(32'h02, 8);
        sendBits(32'h40, 8);
        sendBits(32'h99, 8);
        endFrame();
        check("after_reset_mem_40", {24'b0, mem[8'h40]}, 32'h0);
        check("after_reset_done_count", doneCnt - d0, 0);

        d0 = doneCnt;
        reQ.push_back(8'h20);
        reQ.push_back(8'h21);
        reQ.push_back(8'h22);
        misoQ.push_back(8'h3C);
        misoQ.push_back(8'hC3);
        readFrame(8'h20, 16);
        check("reread_done_count", doneCnt - d0, 2);

        #200;
        check("write_queue_drained", weQ.size(), 0);
        check("read_queue_drained", reQ.size(), 0);
        check("miso_queue_drained", misoQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
